// File: rtl/calc_pkg.sv
// Shared key codes, ALU opcodes, sequencer state encoding and key decode helpers
// for the calculator key sequencer.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_AND = 4'd12;
    localparam logic [3:0] KEY_OR  = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [2:0] OPT_NOP = 3'd0;
    localparam logic [2:0] OPT_ADD = 3'd1;
    localparam logic [2:0] OPT_SUB = 3'd2;
    localparam logic [2:0] OPT_AND = 3'd3;
    localparam logic [2:0] OPT_OR  = 3'd4;

    localparam logic [1:0] ST_ENTER_A = 2'd0;
    localparam logic [1:0] ST_ENTER_B = 2'd1;
    localparam logic [1:0] ST_EXEC    = 2'd2;
    localparam logic [1:0] ST_SHOW    = 2'd3;

    function automatic logic [2:0] key_to_opt(input logic [3:0] code);
        case (code)
            KEY_ADD: return OPT_ADD;
            KEY_SUB: return OPT_SUB;
            KEY_AND: return OPT_AND;
            KEY_OR:  return OPT_OR;
            default: return OPT_NOP;
        endcase
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/calc_dec_acc.sv
// Decimal operand accumulator: appends digits (acc*10+d), counts accepted digits and
// flags a digit that would overflow W bits or exceed MAX_DIG digits.
module calc_dec_acc #(
    parameter int W       = 8,
    parameter int MAX_DIG = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         digit_en,
    input  logic         fresh,
    input  logic [3:0]   digit,
    output logic [W-1:0] acc,
    output logic         has_digit,
    output logic         ovf
);

    localparam int CW = $clog2(MAX_DIG + 1);

    logic [W-1:0]  acc_reg;
    logic [CW-1:0] cnt_reg;
    logic [W+3:0]  base;
    logic [W+3:0]  cand;
    logic [CW-1:0] cnt_base;

    // A fresh digit starts a new operand, so it is applied to an empty accumulator.
    always_comb begin
        base     = fresh ? '0 : {4'b0000, acc_reg};
        cnt_base = fresh ? '0 : cnt_reg;
        cand     = base * (W+4)'(10) + {{W{1'b0}}, digit};
        ovf      = digit_en && ((cand > {4'b0000, {W{1'b1}}}) || (cnt_base >= CW'(MAX_DIG)));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            acc_reg <= load_val;
            cnt_reg <= '0;
        end else if (digit_en && !ovf) begin
            acc_reg <= cand[W-1:0];
            cnt_reg <= cnt_base + CW'(1);
        end
    end

    assign acc       = acc_reg;
    assign has_digit = (cnt_reg != '0);

endmodule

// File: rtl/calc_key_sequencer.sv
// Key-driven operand builder and one-cycle ALU execute/capture stage.
// Optional build macro CALC_SEQ_CHAIN_EN: an operator after B digits executes and chains.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int W       = 8,
    parameter int MAX_DIG = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [3:0]   key_code,
    output logic [2:0]   alu_opt,
    output logic [W-1:0] alu_numa,
    output logic [W-1:0] alu_numb,
    output logic [W-1:0] alu_ci,
    input  logic [W-1:0] alu_s,
    input  logic         alu_co,
    input  logic         alu_zero,
    output logic [W-1:0] res,
    output logic         res_co,
    output logic         res_zero,
    output logic         res_valid,
    output logic [W-1:0] disp,
    output logic         err,
    output logic         busy
);

    localparam int IA = 0;
    localparam int IB = 1;

    logic [1:0]   state_reg, state_next;
    logic [2:0]   op_reg, op_next, new_opt;
    logic [2:0]   alu_opt_reg;
    logic [W-1:0] numa_reg, numb_reg, res_reg;
    logic         res_co_reg, res_zero_reg, res_valid_reg, err_reg;
    logic         accept, key_is_digit, key_is_eq, key_is_clr, exec_start;

    logic [1:0]   acc_clr, acc_load, acc_digit_en, acc_fresh, acc_has, acc_ovf;
    logic [W-1:0] acc_load_val;
    logic [W-1:0] acc_val [2];

`ifdef CALC_SEQ_CHAIN_EN
    logic         chain_reg, chain_next;
    logic [2:0]   chain_op_reg;
`endif

    assign key_ready    = (state_reg != ST_EXEC);
    assign busy         = (state_reg == ST_EXEC);
    assign accept       = key_valid && key_ready;
    assign key_is_digit = is_digit(key_code);
    assign key_is_eq    = (key_code == KEY_EQ);
    assign key_is_clr   = (key_code == KEY_CLR);
    assign new_opt      = key_to_opt(key_code);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            calc_dec_acc #(.W(W), .MAX_DIG(MAX_DIG)) u_acc (
                .clk       (clk),
                .rst       (rst),
                .clr       (acc_clr[gi]),
                .load      (acc_load[gi]),
                .load_val  (acc_load_val),
                .digit_en  (acc_digit_en[gi]),
                .fresh     (acc_fresh[gi]),
                .digit     (key_code),
                .acc       (acc_val[gi]),
                .has_digit (acc_has[gi]),
                .ovf       (acc_ovf[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        exec_start   = 1'b0;
        acc_clr      = '0;
        acc_load     = '0;
        acc_digit_en = '0;
        acc_fresh    = '0;
        acc_load_val = '0;
`ifdef CALC_SEQ_CHAIN_EN
        chain_next   = 1'b0;
`endif
        if (state_reg == ST_EXEC) begin
            state_next = ST_SHOW;
`ifdef CALC_SEQ_CHAIN_EN
            if (chain_reg) begin
                state_next       = ST_ENTER_B;
                op_next          = chain_op_reg;
                acc_load[IA]     = 1'b1;
                acc_load_val     = alu_s;
                acc_clr[IB]      = 1'b1;
            end
`endif
        end else if (accept) begin
            if (key_is_clr) begin
                state_next = ST_ENTER_A;
                op_next    = OPT_NOP;
                acc_clr    = '1;
            end else if (key_is_digit) begin
                case (state_reg)
                    ST_ENTER_A: acc_digit_en[IA] = 1'b1;
                    ST_ENTER_B: acc_digit_en[IB] = 1'b1;
                    default: begin
                        acc_digit_en[IA] = 1'b1;
                        acc_fresh[IA]    = 1'b1;
                        acc_clr[IB]      = 1'b1;
                        state_next       = ST_ENTER_A;
                    end
                endcase
            end else if (key_is_eq) begin
                if (state_reg == ST_ENTER_B) begin
                    state_next = ST_EXEC;
                    exec_start = 1'b1;
                end
            end else begin
                // Any operator (re)starts B entry; from SHOW the last result becomes A.
                acc_clr[IB] = 1'b1;
                state_next  = ST_ENTER_B;
                op_next     = new_opt;
                if (state_reg == ST_SHOW) begin
                    acc_load[IA] = 1'b1;
                    acc_load_val = res_reg;
                end
`ifdef CALC_SEQ_CHAIN_EN
                if (state_reg == ST_ENTER_B && acc_has[IB]) begin
                    state_next = ST_EXEC;
                    exec_start = 1'b1;
                    chain_next = 1'b1;
                    op_next    = op_reg;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_ENTER_A;
            op_reg        <= OPT_NOP;
            alu_opt_reg   <= OPT_NOP;
            numa_reg      <= '0;
            numb_reg      <= '0;
            res_reg       <= '0;
            res_co_reg    <= 1'b0;
            res_zero_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            alu_opt_reg   <= OPT_NOP;
            res_valid_reg <= 1'b0;
            if (exec_start) begin
                alu_opt_reg <= op_reg;
                numa_reg    <= acc_val[IA];
                numb_reg    <= acc_val[IB];
            end
            if (state_reg == ST_EXEC) begin
                res_reg       <= alu_s;
                res_co_reg    <= alu_co;
                res_zero_reg  <= alu_zero;
                res_valid_reg <= 1'b1;
            end
            if (accept && key_is_clr) begin
                err_reg  <= 1'b0;
                numa_reg <= '0;
                numb_reg <= '0;
            end else begin
                err_reg <= err_reg | (|acc_ovf);
            end
        end
    end

`ifdef CALC_SEQ_CHAIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg    <= 1'b0;
            chain_op_reg <= OPT_NOP;
        end else begin
            chain_reg <= chain_next;
            if (chain_next) begin
                chain_op_reg <= new_opt;
            end
        end
    end
`endif

    // B shows A until its first digit so the user still sees the left operand.
    always_comb begin
        case (state_reg)
            ST_ENTER_A: disp = acc_has[IA] ? acc_val[IA] : '0;
            ST_ENTER_B: disp = acc_has[IB] ? acc_val[IB] : acc_val[IA];
            default:    disp = res_reg;
        endcase
    end

    assign alu_opt   = alu_opt_reg;
    assign alu_numa  = numa_reg;
    assign alu_numb  = numb_reg;
    assign alu_ci    = '0;
    assign res       = res_reg;
    assign res_co    = res_co_reg;
    assign res_zero  = res_zero_reg;
    assign res_valid = res_valid_reg;
    assign err       = err_reg;

endmodule
